// File: rtl/sc_hdlc_axis_unpacker_pkg.sv
// Shared HDLC frame-buffer definitions: FSM encodings, byte width and default frame limits
// (the limits are the same ones the transmit-side packer uses).
package sc_hdlc_axis_unpacker_pkg;

    localparam int BYTE_W       = 8;
    localparam int HDLC_MIN_LEN = 4;
    localparam int HDLC_MAX_LEN = 1024;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RECV = 2'd1,
        W_DISC = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } r_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sc_hdlc_axis_unpacker_if.sv
// Byte-wide AXI-Stream bundle used on both sides of the HDLC unpacker.
interface sc_hdlc_axis_unpacker_if;
    import sc_hdlc_axis_unpacker_pkg::*;

    logic [BYTE_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/sc_hdlc_frame_ram.sv
// Frame byte store: one write port, one registered read port that holds its output when not enabled.
module sc_hdlc_frame_ram
    import sc_hdlc_axis_unpacker_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);
    logic [BYTE_W-1:0] mem [2 ** ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/sc_hdlc_axis_unpacker.sv
// HDLC receive frame buffer: stores whole valid frames from a non-stallable byte stream and replays
// one per download_req. Define SC_HDLC_UNPACKER_FCS_DROP_EN to discard frames with tuser set on tlast.
//  state  | meaning
//  W_IDLE | waiting for the first byte of a frame
//  W_RECV | storing frame bytes
//  W_DISC | frame already doomed, swallowing bytes until tlast
//  R_IDLE | no download in progress
//  R_SEND | streaming the popped frame to the host
module sc_hdlc_axis_unpacker
    import sc_hdlc_axis_unpacker_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int LEN_W   = 16,
    parameter int DESC_W  = 4,
    parameter int MIN_LEN = HDLC_MIN_LEN,
    parameter int MAX_LEN = HDLC_MAX_LEN
) (
    input  logic                    clk,
    input  logic                    rstn,
    sc_hdlc_axis_unpacker_if.slave  s_axis,
    sc_hdlc_axis_unpacker_if.master m_axis,
    input  logic                    download_req,
    output logic                    download_busy,
    output logic                    download_done,
    output logic                    frame_avail,
    output logic [LEN_W-1:0]        frame_len,
    output logic [15:0]             drop_cnt,
    output logic                    rx_commit,
    output logic                    rx_drop
);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int DESC_N = 2 ** DESC_W;
    localparam logic [PTR_W-1:0] RAM_DEPTH = PTR_W'(2 ** ADDR_W);
    localparam logic [DESC_W:0]  DESC_FULL = (DESC_W + 1)'(DESC_N);
`ifdef SC_HDLC_UNPACKER_FCS_DROP_EN
    localparam bit FCS_DROP = 1'b1;
`else
    localparam bit FCS_DROP = 1'b0;
`endif

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [PTR_W-1:0]  wr_ptr, wr_base, rd_ptr;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic              s_ready, beat, ovf, len_ok, fcs_bad, desc_full;
    logic              wr_en, commit, drop;

    logic [LEN_W-1:0]  desc_mem [DESC_N];
    logic [DESC_W-1:0] desc_wa, desc_ra;
    logic [DESC_W:0]   desc_cnt;

    logic [LEN_W-1:0]  fetch_rem;
    logic              pop, issue, out_fire, out_load, last_fire;
    logic              ram_valid, ram_last, out_valid, out_last;
    logic [BYTE_W-1:0] ram_rdata, out_data;

    assign beat      = s_axis.tvalid & s_ready;
    assign ovf       = (wr_ptr - rd_ptr) == RAM_DEPTH;
    assign len_nxt   = len_q + 1'b1;
    assign len_ok    = (len_nxt >= LEN_W'(MIN_LEN)) && (len_nxt <= LEN_W'(MAX_LEN));
    assign fcs_bad   = FCS_DROP & s_axis.tuser;
    assign desc_full = desc_cnt == DESC_FULL;

    always_ff @(posedge clk) begin
        if (!rstn) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE, W_RECV: begin
                if (beat) begin
                    if (s_axis.tlast)                                w_state_nxt = W_IDLE;
                    else if (ovf || len_nxt == LEN_W'(MAX_LEN))      w_state_nxt = W_DISC;
                    else                                             w_state_nxt = W_RECV;
                end
            end
            W_DISC:  if (beat && s_axis.tlast) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // The tlast byte is written even when the frame fails; the rollback discards it anyway.
    always_comb begin
        wr_en  = 1'b0;
        commit = 1'b0;
        drop   = 1'b0;
        case (w_state)
            W_IDLE, W_RECV: begin
                if (beat) begin
                    wr_en = !ovf;
                    if (s_axis.tlast) begin
                        commit = !ovf && len_ok && !desc_full && !fcs_bad;
                        drop   = !commit;
                    end
                end
            end
            W_DISC:  drop = beat & s_axis.tlast;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_ready   <= 1'b0;
            wr_ptr    <= '0;
            wr_base   <= '0;
            len_q     <= '0;
            drop_cnt  <= '0;
            rx_commit <= 1'b0;
            rx_drop   <= 1'b0;
        end else begin
            s_ready   <= 1'b1;
            rx_commit <= commit;
            rx_drop   <= drop;
            if (commit) begin
                wr_ptr  <= wr_ptr + 1'b1;
                wr_base <= wr_ptr + 1'b1;
            end else if (drop) begin
                wr_ptr  <= wr_base;
            end else if (wr_en) begin
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (w_state_nxt != W_RECV) len_q <= '0;
            else if (wr_en)            len_q <= len_nxt;
            if (drop) drop_cnt <= sat_inc16(drop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (commit) desc_mem[desc_wa] <= len_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            desc_wa  <= '0;
            desc_ra  <= '0;
            desc_cnt <= '0;
        end else begin
            if (commit) desc_wa <= desc_wa + 1'b1;
            if (pop)    desc_ra <= desc_ra + 1'b1;
            desc_cnt <= desc_cnt + (DESC_W + 1)'(commit) - (DESC_W + 1)'(pop);
        end
    end

    assign frame_avail = desc_cnt != '0;
    assign frame_len   = frame_avail ? desc_mem[desc_ra] : '0;

    assign out_fire  = out_valid & m_axis.tready;
    assign out_load  = ram_valid & (!out_valid | out_fire);
    assign last_fire = out_fire & out_last;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        if (r_state == R_IDLE) begin
            if (download_req && frame_avail) r_state_nxt = R_SEND;
        end else if (last_fire) begin
            r_state_nxt = R_IDLE;
        end
    end

    // RAM read stage refills whenever it is empty or hands its byte to the output register.
    always_comb begin
        pop           = 1'b0;
        issue         = 1'b0;
        download_busy = 1'b0;
        if (r_state == R_IDLE) begin
            pop = download_req & frame_avail;
        end else begin
            download_busy = 1'b1;
            issue         = (fetch_rem != '0) && (!ram_valid || out_load);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr        <= '0;
            fetch_rem     <= '0;
            ram_valid     <= 1'b0;
            ram_last      <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_data      <= '0;
            download_done <= 1'b0;
        end else begin
            download_done <= last_fire;
            if (pop)        fetch_rem <= frame_len;
            else if (issue) fetch_rem <= fetch_rem - 1'b1;
            if (issue) begin
                rd_ptr   <= rd_ptr + 1'b1;
                ram_last <= fetch_rem == LEN_W'(1);
            end
            ram_valid <= issue | (ram_valid & !out_load);
            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= ram_rdata;
                out_last  <= ram_last;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_valid & out_last;
    assign m_axis.tuser  = 1'b0;

    sc_hdlc_frame_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (s_axis.tdata),
        .rd_en   (issue),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_rdata)
    );
endmodule

// File: tb/tb_sc_hdlc_axis_unpacker.sv
// Bench for sc_hdlc_axis_unpacker: directed and random frames against a queue-based model of
// pending frames (commit rules computed from lengths, buffer occupancy and descriptor count).
module tb_sc_hdlc_axis_unpacker;
    localparam int ADDR_W  = 7;
    localparam int LEN_W   = 16;
    localparam int DESC_W  = 4;
    localparam int MIN_LEN = 4;
    localparam int MAX_LEN = 48;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int DESC_N  = 2 ** DESC_W;
`ifdef SC_HDLC_UNPACKER_FCS_DROP_EN
    localparam bit FCS_DROP = 1'b1;
`else
    localparam bit FCS_DROP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             download_req = 1'b0;
    logic             download_busy, download_done, frame_avail, rx_commit, rx_drop;
    logic [LEN_W-1:0] frame_len;
    logic [15:0]      drop_cnt;

    sc_hdlc_axis_unpacker_if s_if();
    sc_hdlc_axis_unpacker_if m_if();

    int              checks = 0;
    int              errors = 0;
    logic [7:0]      mdl_bytes[$];
    int              mdl_lens[$];
    logic [15:0]     mdl_drops = '0;
    logic [ADDR_W:0] mdl_wr = '0;

    sc_hdlc_axis_unpacker #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DESC_W(DESC_W), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .download_req  (download_req),
        .download_busy (download_busy),
        .download_done (download_done),
        .frame_avail   (frame_avail),
        .frame_len     (frame_len),
        .drop_cnt      (drop_cnt),
        .rx_commit     (rx_commit),
        .rx_drop       (rx_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; optionally raise download_req on its tlast beat (returns the popped length).
    task automatic send_frame(input int len, input bit tuser, input bit req_on_last, output int popped);
        logic [7:0] fb[$];
        bit         commit;
        popped = 0;
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
        if (req_on_last) begin
            check("pre_req_avail", frame_avail, 1);
            check("pre_req_len", frame_len, mdl_lens[0]);
            popped = mdl_lens[0];
        end
        commit = (len >= MIN_LEN) && (len <= MAX_LEN) && (mdl_lens.size() < DESC_N) &&
                 (mdl_bytes.size() + len <= DEPTH) && !(FCS_DROP && tuser);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(3) == 0) begin
                s_if.tvalid = 1'b0;
                tick();
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = fb[i];
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = (i == len - 1) ? tuser : 1'($urandom);
            if (i == len - 1 && req_on_last) download_req = 1'b1;
            tick();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        download_req = 1'b0;
        if (req_on_last) void'(mdl_lens.pop_front());
        if (commit) begin
            mdl_lens.push_back(len);
            foreach (fb[i]) mdl_bytes.push_back(fb[i]);
            mdl_wr = mdl_wr + (ADDR_W + 1)'(len);
        end else if (mdl_drops != 16'hFFFF) begin
            mdl_drops = mdl_drops + 16'd1;
        end
        check("rx_commit", rx_commit, commit);
        check("rx_drop", rx_drop, !commit);
        check("drop_cnt", drop_cnt, mdl_drops);
        check("frame_avail", frame_avail, mdl_lens.size() != 0);
        check("wr_ptr", dut.wr_ptr, mdl_wr);
        if (req_on_last) check("busy_on_req", download_busy, 1);
        else begin
            tick();
            check("rx_pulse_width", rx_commit | rx_drop, 0);
        end
    endtask

    // Entry: just after the edge that sampled an accepted download_req. mode 0 ready, 1 toggle, 2 random.
    task automatic stream_out(input int len, input int mode);
        int         got = 0;
        int         cyc = 0;
        bit         prev_stall = 1'b0;
        bit         rdy;
        logic [7:0] held = '0;
        check("busy_set", download_busy, 1);
        check("lat0_tvalid", m_if.tvalid, 0);
        tick();
        check("lat1_tvalid", m_if.tvalid, 0);
        tick();
        check("lat2_tvalid", m_if.tvalid, 1);
        while (got < len && cyc < 4 * len + 20) begin
            if (prev_stall) begin
                check("stall_valid", m_if.tvalid, 1);
                check("stall_data", m_if.tdata, held);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2) == 0;
                default: rdy = $urandom_range(1) == 1;
            endcase
            m_if.tready  = rdy;
            download_req = (got == 1);
            if (m_if.tvalid && rdy) begin
                check("data", m_if.tdata, mdl_bytes.pop_front());
                check("tlast", m_if.tlast, got == len - 1);
                got++;
            end
            prev_stall = m_if.tvalid && !rdy;
            held       = m_if.tdata;
            tick();
            cyc++;
        end
        download_req = 1'b0;
        m_if.tready  = 1'b0;
        check("stream_count", got, len);
        check("done_pulse", download_done, 1);
        check("busy_clear", download_busy, 0);
        check("tvalid_clear", m_if.tvalid, 0);
        tick();
        check("done_width", download_done, 0);
    endtask

    task automatic download(input int mode);
        int len;
        if (mdl_lens.size() == 0) begin
            download_req = 1'b1;
            tick();
            download_req = 1'b0;
            check("empty_req_busy", download_busy, 0);
            repeat (3) tick();
            check("empty_req_valid", m_if.tvalid, 0);
            check("empty_req_done", download_done, 0);
            return;
        end
        check("frame_len", frame_len, mdl_lens[0]);
        len = mdl_lens.pop_front();
        download_req = 1'b1;
        tick();
        download_req = 1'b0;
        check("avail_after_pop", frame_avail, mdl_lens.size() != 0);
        stream_out(len, mode);
    endtask

    initial begin
        int dummy;
        int len_a;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;

        repeat (3) tick();
        check("rst_s_tready", s_if.tready, 0);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_busy", download_busy, 0);
        check("rst_avail", frame_avail, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rstn = 1'b1;
        tick();
        check("s_tready_up", s_if.tready, 1);

        // 10-byte frame round trip
        send_frame(10, 1'b0, 1'b0, dummy);
        check("t1_len", frame_len, 10);
        download(0);

        // short frame, then a request with nothing pending
        send_frame(3, 1'b0, 1'b0, dummy);
        check("t2_drop_cnt", drop_cnt, 1);
        check("t2_avail", frame_avail, 0);
        download(0);

        // length boundaries
        send_frame(MIN_LEN, 1'b0, 1'b0, dummy);
        send_frame(MAX_LEN, 1'b0, 1'b0, dummy);
        send_frame(MAX_LEN + 1, 1'b0, 1'b0, dummy);
        repeat (2) download(2);

        // buffer overflow with rollback, then an exact fill
        send_frame(48, 1'b0, 1'b0, dummy);
        send_frame(48, 1'b0, 1'b0, dummy);
        send_frame(40, 1'b0, 1'b0, dummy);
        send_frame(32, 1'b0, 1'b0, dummy);
        repeat (3) download(2);

        // descriptor FIFO full
        repeat (DESC_N + 1) send_frame(4, 1'b0, 1'b0, dummy);
        repeat (DESC_N) download(0);
        check("t4_empty", frame_avail, 0);

        // stall every other cycle
        send_frame(20, 1'b0, 1'b0, dummy);
        download(1);

        // FCS-flagged frame
        send_frame(10, 1'b1, 1'b0, dummy);
        download(0);

        // commit and pop on the same edge
        send_frame(8, 1'b0, 1'b0, dummy);
        send_frame(6, 1'b0, 1'b1, len_a);
        stream_out(len_a, 2);
        download(2);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            send_frame(int'($urandom_range(MAX_LEN + 6, 1)), $urandom_range(3) == 0, 1'b0, dummy);
            if ($urandom_range(2) == 0) download(2);
        end
        while (mdl_lens.size() != 0) download(2);

        // reset in the middle of a download
        send_frame(20, 1'b0, 1'b0, dummy);
        send_frame(3, 1'b0, 1'b0, dummy);
        void'(mdl_lens.pop_front());
        download_req = 1'b1;
        tick();
        download_req = 1'b0;
        m_if.tready  = 1'b1;
        repeat (4) tick();
        rstn = 1'b0;
        tick();
        check("mid_rst_s_tready", s_if.tready, 0);
        check("mid_rst_tvalid", m_if.tvalid, 0);
        check("mid_rst_tdata", m_if.tdata, 0);
        check("mid_rst_tlast", m_if.tlast, 0);
        check("mid_rst_busy", download_busy, 0);
        check("mid_rst_done", download_done, 0);
        check("mid_rst_avail", frame_avail, 0);
        check("mid_rst_frame_len", frame_len, 0);
        check("mid_rst_drop_cnt", drop_cnt, 0);
        check("mid_rst_pulses", rx_commit | rx_drop, 0);
        rstn = 1'b1;
        m_if.tready = 1'b0;
        tick();
        mdl_bytes.delete();
        mdl_lens.delete();
        mdl_drops = '0;
        mdl_wr    = '0;
        check("post_rst_s_tready", s_if.tready, 1);
        send_frame(12, 1'b0, 1'b0, dummy);
        download(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
